// File: rtl/hall_if.sv
// Hall conditioner bus: raw Hall inputs and controls toward the conditioner,
// cleaned Hall code, qualifiers and strobes back toward the gate driver.
//   hall_in[2:0]  raw asynchronous Hall inputs {C,B,A}
//   dir           commanded direction (0 forward, 1 reverse)
//   fault_clr     one-cycle request to leave FAULT
//   hall_out[2:0] accepted Hall code
//   hall_valid    high only while running
//   edge_pulse    strobe per in-sequence accepted code
//   seq_err       strobe per sequence or illegal-code error
//   fault         high while in FAULT
//   period        cycles between the last two edge_pulses
//   period_valid  period holds a real measurement
interface hall_if #(
  parameter int unsigned PERIOD_W = 20
) ();
  logic [2:0]          hall_in;
  logic                dir;
  logic                fault_clr;
  logic [2:0]          hall_out;
  logic                hall_valid;
  logic                edge_pulse;
  logic                seq_err;
  logic                fault;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;

  modport master (
    output hall_in, dir, fault_clr,
    input  hall_out, hall_valid, edge_pulse, seq_err, fault, period, period_valid
  );

  modport slave (
    input  hall_in, dir, fault_clr,
    output hall_out, hall_valid, edge_pulse, seq_err, fault, period, period_valid
  );
endinterface

// File: rtl/hall_conditioner.sv
// BLDC Hall-sensor conditioner: synchronises and debounces the raw Hall
// inputs, rejects illegal codes, checks the commutation sequence against the
// commanded direction and qualifies the result for the gate driver.
// Optional feature macro: HALL_PERIOD_EN (edge-to-edge period measurement).
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  hall_if slave modport (see hall_if.sv for signal list)
module hall_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FAULT_LIMIT     = 3,
  parameter int unsigned PERIOD_W        = 20
) (
  input  logic  clk,
  input  logic  rst,
  hall_if.slave bus
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned EW = $clog2(FAULT_LIMIT + 1);
  localparam logic [DW-1:0] DMAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [EW-1:0] ELIM  = EW'(FAULT_LIMIT);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} state_e;

  state_e        state_q, state_d;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    cand_q, cand_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [2:0]    hall_q, hall_d;
  logic [EW-1:0] err_q, err_d;
  logic          ill_done_q, ill_done_d;
  logic          dir_q;
  logic          edge_q, edge_d;
  logic          serr_q, serr_d;
  logic          valid_q, fault_q;
  logic          stable_c, event_c, legal_c, err_bump_c;
  logic [2:0]    expect_c;

  // Successor of a legal code around the commutation cycle in either direction.
  function automatic logic [2:0] next_code(input logic [2:0] code, input logic rev);
    logic [2:0] nxt;
    nxt = 3'b000;
    case (code)
      3'b001: nxt = rev ? 3'b101 : 3'b011;
      3'b011: nxt = rev ? 3'b001 : 3'b010;
      3'b010: nxt = rev ? 3'b011 : 3'b110;
      3'b110: nxt = rev ? 3'b010 : 3'b100;
      3'b100: nxt = rev ? 3'b110 : 3'b101;
      3'b101: nxt = rev ? 3'b100 : 3'b001;
      default: nxt = 3'b000;
    endcase
    return nxt;
  endfunction

  // Next-state, debounce and output logic.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    dcnt_d     = dcnt_q;
    hall_d     = hall_q;
    err_d      = err_q;
    ill_done_d = ill_done_q;
    edge_d     = 1'b0;
    serr_d     = 1'b0;
    err_bump_c = 1'b0;

    stable_c = (dcnt_q == DMAX);
    event_c  = stable_c && (cand_q != hall_q);
    legal_c  = (cand_q != 3'b000) && (cand_q != 3'b111);
    expect_c = next_code(hall_q, dir_q);

    case (state_q)
      ST_INIT: begin
        if (event_c && legal_c) begin
          hall_d  = cand_q;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (event_c) begin
          if (!legal_c) begin
            // An illegal code persists as an event; report it only once.
            if (!ill_done_q) begin
              serr_d     = 1'b1;
              ill_done_d = 1'b1;
              err_bump_c = 1'b1;
            end
          end else if (cand_q == expect_c) begin
            hall_d = cand_q;
            edge_d = 1'b1;
            err_d  = '0;
          end else begin
            hall_d     = cand_q;
            serr_d     = 1'b1;
            err_bump_c = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr) begin
          state_d = ST_INIT;
          err_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (err_bump_c) begin
      err_d = err_q + EW'(1);
      if (err_d >= ELIM) state_d = ST_FAULT;
    end

    // Debounce: a new synchronised code restarts the stability count and
    // re-arms illegal-code reporting (overrides any set above).
    if (sync2_q != cand_q) begin
      cand_d     = sync2_q;
      dcnt_d     = '0;
      ill_done_d = 1'b0;
    end else if (dcnt_q != DMAX) begin
      dcnt_d = dcnt_q + DW'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      cand_q     <= 3'b000;
      dcnt_q     <= '0;
      hall_q     <= 3'b000;
      err_q      <= '0;
      ill_done_q <= 1'b0;
      dir_q      <= 1'b0;
      edge_q     <= 1'b0;
      serr_q     <= 1'b0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= bus.hall_in;
      sync2_q    <= sync1_q;
      cand_q     <= cand_d;
      dcnt_q     <= dcnt_d;
      hall_q     <= hall_d;
      err_q      <= err_d;
      ill_done_q <= ill_done_d;
      dir_q      <= bus.dir;
      edge_q     <= edge_d;
      serr_q     <= serr_d;
      valid_q    <= (state_d == ST_RUN);
      fault_q    <= (state_d == ST_FAULT);
    end
  end

  assign bus.hall_out   = hall_q;
  assign bus.hall_valid = valid_q;
  assign bus.edge_pulse = edge_q;
  assign bus.seq_err    = serr_q;
  assign bus.fault      = fault_q;

`ifdef HALL_PERIOD_EN
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                armed_q, armed_d;
  logic                pvalid_q, pvalid_d;
  logic                psat_c;

  // Period counter: reloads to 1 on each edge so the captured value is the
  // exact cycle distance between edge_pulses; the first edge after entering
  // RUN only arms the measurement.
  always_comb begin
    psat_c   = (pcnt_q == '1);
    pcnt_d   = psat_c ? pcnt_q : pcnt_q + PERIOD_W'(1);
    period_d = period_q;
    armed_d  = armed_q;
    pvalid_d = pvalid_q;
    if (edge_d) begin
      period_d = pcnt_q;
      pcnt_d   = PERIOD_W'(1);
      armed_d  = 1'b1;
      pvalid_d = armed_q && !psat_c;
    end else if (psat_c) begin
      armed_d  = 1'b0;
      pvalid_d = 1'b0;
    end
    if (state_d != ST_RUN) begin
      armed_d  = 1'b0;
      pvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q   <= '0;
      period_q <= '0;
      armed_q  <= 1'b0;
      pvalid_q <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      armed_q  <= armed_d;
      pvalid_q <= pvalid_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pvalid_q;
`else
  assign bus.period       = PERIOD_W'(0);
  assign bus.period_valid = 1'b0;
`endif

endmodule
